// File: rtl/buf_arb_pkg.sv
// Shared types for the buffer write-port arbiter.
// Stats counters are enabled with BUF_ARB_STATS_EN.
package buf_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'b00,
    OWN_HOST = 2'b01,
    OWN_ARR  = 2'b10
  } owner_e;

  typedef enum logic [1:0] {
    IDLE,
    GNT_HOST,
    GNT_ARR
  } arb_state_e;

  localparam int STAT_W = 16;

  function automatic owner_e state_owner(
    input arb_state_e s
  );
    owner_e o;
    o = OWN_NONE;
    unique case (1'b1)
      (s == GNT_HOST): o = OWN_HOST;
      (s == GNT_ARR):  o = OWN_ARR;
      default:         o = OWN_NONE;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/buf_wr_arbiter_if.sv
// Requester handshakes and buffer write port of buf_wr_arbiter.
// master = requester/buffer side, slave = arbiter side.
interface buf_wr_arbiter_if
  import buf_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16
) ();

  logic                 h_valid;
  logic                 h_last;
  logic [ADDR_SIZE-1:0] h_addr;
  logic [WORD_SIZE-1:0] h_data;
  logic                 h_ready;

  logic                 a_valid;
  logic                 a_last;
  logic [ADDR_SIZE-1:0] a_addr;
  logic [WORD_SIZE-1:0] a_data;
  logic                 a_ready;

  logic                 w_en;
  logic [ADDR_SIZE-1:0] w_addr;
  logic [WORD_SIZE-1:0] w_data;
  owner_e               owner;

  modport master (
    output h_valid, h_last, h_addr, h_data,
    output a_valid, a_last, a_addr, a_data,
    input  h_ready, a_ready,
    input  w_en, w_addr, w_data, owner
  );

  modport slave (
    input  h_valid, h_last, h_addr, h_data,
    input  a_valid, a_last, a_addr, a_data,
    output h_ready, a_ready,
    output w_en, w_addr, w_data, owner
  );

endinterface

// File: rtl/buf_arb_sat_cnt.sv
// Saturating event counter with asynchronous active-high reset.
// Used for beat statistics under BUF_ARB_STATS_EN.
module buf_arb_sat_cnt
  import buf_arb_pkg::*;
#(
  parameter int W = STAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/buf_wr_arbiter.sv
// Two-requester burst arbiter for the buffer write port.
// BUF_ARB_STATS_EN adds saturating h_beats/a_beats counters.
module buf_wr_arbiter
  import buf_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 16,
  parameter int MAX_BURST = 64
) (
  input  logic        clk,
  input  logic        rst,
`ifdef BUF_ARB_STATS_EN
  output logic [15:0] h_beats,
  output logic [15:0] a_beats,
`endif
  buf_wr_arbiter_if.slave bus
);

  localparam int CW = $clog2(MAX_BURST);
  localparam logic [CW-1:0] CYC_MAX = CW'(MAX_BURST - 1);

  arb_state_e    state;
  arb_state_e    state_nxt;
  owner_e        last_owner;
  owner_e        last_nxt;
  logic [CW-1:0] cyc_cnt;
  logic [CW-1:0] cyc_nxt;

  logic acc_h;
  logic acc_a;
  logic tenure_up;

  assign acc_h     = bus.h_valid && (state == GNT_HOST);
  assign acc_a     = bus.a_valid && (state == GNT_ARR);
  assign tenure_up = (cyc_cnt == CYC_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_owner <= OWN_ARR;
      cyc_cnt    <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_nxt;
      cyc_cnt    <= cyc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    last_nxt  = last_owner;
    cyc_nxt   = cyc_cnt;
    unique case (1'b1)
      (state == GNT_HOST): begin
        if (acc_h && bus.h_last) begin
          last_nxt  = OWN_HOST;
          cyc_nxt   = '0;
          state_nxt = bus.a_valid ? GNT_ARR : IDLE;
        end else if (tenure_up && bus.a_valid) begin
          last_nxt  = OWN_HOST;
          cyc_nxt   = '0;
          state_nxt = GNT_ARR;
        end else if (!tenure_up) begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      (state == GNT_ARR): begin
        if (acc_a && bus.a_last) begin
          last_nxt  = OWN_ARR;
          cyc_nxt   = '0;
          state_nxt = bus.h_valid ? GNT_HOST : IDLE;
        end else if (tenure_up && bus.h_valid) begin
          last_nxt  = OWN_ARR;
          cyc_nxt   = '0;
          state_nxt = GNT_HOST;
        end else if (!tenure_up) begin
          cyc_nxt = cyc_cnt + 1'b1;
        end
      end
      default: begin
        cyc_nxt = '0;
        // On a tie the requester that did not hold the last tenure wins
        if (bus.h_valid && bus.a_valid) begin
          state_nxt = (last_owner == OWN_HOST) ? GNT_ARR : GNT_HOST;
        end else if (bus.h_valid) begin
          state_nxt = GNT_HOST;
        end else if (bus.a_valid) begin
          state_nxt = GNT_ARR;
        end
      end
    endcase
  end

  always_comb begin
    bus.h_ready = (state == GNT_HOST);
    bus.a_ready = (state == GNT_ARR);
    bus.owner   = state_owner(state);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.w_en   <= 1'b0;
      bus.w_addr <= '0;
      bus.w_data <= '0;
    end else begin
      bus.w_en <= acc_h || acc_a;
      if (acc_h) begin
        bus.w_addr <= bus.h_addr;
        bus.w_data <= bus.h_data;
      end else if (acc_a) begin
        bus.w_addr <= bus.a_addr;
        bus.w_data <= bus.a_data;
      end
    end
  end

`ifdef BUF_ARB_STATS_EN
  buf_arb_sat_cnt #(.W(16)) u_h_cnt (
    .clk (clk),
    .rst (rst),
    .inc (acc_h),
    .cnt (h_beats)
  );

  buf_arb_sat_cnt #(.W(16)) u_a_cnt (
    .clk (clk),
    .rst (rst),
    .inc (acc_a),
    .cnt (a_beats)
  );
`endif

endmodule

// File: tb/tb_buf_wr_arbiter.sv
// Randomized and directed bench for buf_wr_arbiter against a tenure-level model.
// Stats checks are active when BUF_ARB_STATS_EN is defined.
module tb_buf_wr_arbiter;
  import buf_arb_pkg::*;

  localparam int AW = 10;
  localparam int DW = 16;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  buf_wr_arbiter_if #(.ADDR_SIZE(AW), .WORD_SIZE(DW)) bus ();

`ifdef BUF_ARB_STATS_EN
  logic [15:0] h_beats;
  logic [15:0] a_beats;
`endif

  buf_wr_arbiter #(
    .ADDR_SIZE (AW),
    .WORD_SIZE (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk     (clk),
    .rst     (rst),
`ifdef BUF_ARB_STATS_EN
    .h_beats (h_beats),
    .a_beats (a_beats),
`endif
    .bus     (bus)
  );

  int n_chk = 0;
  int n_fail = 0;

  // model: 0 = idle, 1 = host, 2 = array; m_ten = grant cycles spent
  int          m_st, m_last, m_ten;
  logic        m_wen;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int          m_hcnt, m_acnt;
  bit          m_acc_h, m_acc_a;

  // requester drivers
  int h_rem, h_idx, h_abase, h_dbase;
  int a_rem, a_idx, a_abase, a_dbase;
  bit h_pause;
  int own_log[$];

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic model_reset();
    m_st = 0; m_last = 2; m_ten = 0;
    m_wen = 1'b0; m_waddr = '0; m_wdata = '0;
    m_hcnt = 0; m_acnt = 0;
    m_acc_h = 0; m_acc_a = 0;
  endtask

  task automatic model_update();
    bit hv, av, ov, lst;
    int me, oth;
    hv = bus.h_valid;
    av = bus.a_valid;
    m_acc_h = (m_st == 1) && hv;
    m_acc_a = (m_st == 2) && av;
    if (m_acc_h) begin
      m_wen = 1'b1; m_waddr = bus.h_addr; m_wdata = bus.h_data;
      m_hcnt++;
    end else if (m_acc_a) begin
      m_wen = 1'b1; m_waddr = bus.a_addr; m_wdata = bus.a_data;
      m_acnt++;
    end else begin
      m_wen = 1'b0;
    end
    if (m_st == 0) begin
      m_ten = 0;
      if (hv && av) m_st = (m_last == 1) ? 2 : 1;
      else if (hv) m_st = 1;
      else if (av) m_st = 2;
    end else begin
      me  = m_st;
      oth = 3 - me;
      ov  = (oth == 1) ? hv : av;
      lst = (me == 1) ? bus.h_last : bus.a_last;
      m_ten++;
      if ((m_acc_h || m_acc_a) && lst) begin
        m_last = me; m_ten = 0;
        m_st = ov ? oth : 0;
      end else if (m_ten >= MB && ov) begin
        m_last = me; m_ten = 0;
        m_st = oth;
      end
    end
  endtask

  task automatic check_all();
    chk("h_ready", bus.h_ready, m_st == 1);
    chk("a_ready", bus.a_ready, m_st == 2);
    chk("owner", bus.owner, m_st);
    chk("w_en", bus.w_en, m_wen);
    chk("w_addr", bus.w_addr, m_waddr);
    chk("w_data", bus.w_data, m_wdata);
`ifdef BUF_ARB_STATS_EN
    chk("h_beats", h_beats, sat16(m_hcnt));
    chk("a_beats", a_beats, sat16(m_acnt));
`endif
  endtask

  task automatic drive_inputs(input bit gaps);
    bus.h_valid = (h_rem > 0) && !h_pause &&
                  (!gaps || $urandom_range(3) != 0);
    bus.h_last  = (h_rem == 1);
    bus.h_addr  = AW'(h_abase + h_idx);
    bus.h_data  = DW'(h_dbase + h_idx);
    bus.a_valid = (a_rem > 0) && (!gaps || $urandom_range(3) != 0);
    bus.a_last  = (a_rem == 1);
    bus.a_addr  = AW'(a_abase + a_idx);
    bus.a_data  = DW'(a_dbase + a_idx);
  endtask

  task automatic run_cycle(input bit gaps);
    drive_inputs(gaps);
    @(posedge clk);
    own_log.push_back(m_st);
    model_update();
    if (m_acc_h) begin h_idx++; h_rem--; end
    if (m_acc_a) begin a_idx++; a_rem--; end
    @(negedge clk);
    check_all();
  endtask

  task automatic run_until_done(input int budget, output int cycles);
    cycles = 0;
    while ((h_rem > 0 || a_rem > 0) && cycles < budget) begin
      run_cycle(1'b0);
      cycles++;
    end
    chk("burst_done", (h_rem > 0 || a_rem > 0), 0);
  endtask

  task automatic start_h(input int n, input int ab, input int db);
    h_rem = n; h_idx = 0; h_abase = ab; h_dbase = db;
  endtask

  task automatic start_a(input int n, input int ab, input int db);
    a_rem = n; a_idx = 0; a_abase = ab; a_dbase = db;
  endtask

  task automatic drv_clear();
    h_rem = 0; h_idx = 0; a_rem = 0; a_idx = 0; h_pause = 0;
    bus.h_valid = 0; bus.h_last = 0; bus.h_addr = '0; bus.h_data = '0;
    bus.a_valid = 0; bus.a_last = 0; bus.a_addr = '0; bus.a_data = '0;
  endtask

  task automatic full_reset();
    rst = 1'b1;
    drv_clear();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    int nh;
    h_abase = 0; h_dbase = 0; a_abase = 0; a_dbase = 0;
    full_reset();
    chk("rst_owner", bus.owner, OWN_NONE);
    chk("rst_w_en", bus.w_en, 0);

    // host-only burst of 4
    start_h(4, 0, 16'hA000);
    run_until_done(20, cyc);
    chk("t1_cycles", cyc, 5);
    chk("t1_last_data", bus.w_data, 16'hA003);
    chk("t1_owner", bus.owner, OWN_NONE);
    run_cycle(1'b0);
    chk("t1_idle_wen", bus.w_en, 0);
    chk("t1_hold_addr", bus.w_addr, 3);

    // ties and handover
    full_reset();
    own_log.delete();
    start_h(2, 16'h010, 16'hB000);
    start_a(2, 16'h020, 16'hC000);
    run_until_done(20, cyc);
    chk("t2_first_host", own_log[1], 1);
    chk("t2_host_last", own_log[2], 1);
    chk("t2_no_bubble", own_log[3], 2);
    own_log.delete();
    start_h(2, 16'h030, 16'hB100);
    start_a(2, 16'h040, 16'hC100);
    run_until_done(20, cyc);
    chk("t2_rr_host", own_log[1], 1);

    // forced release after MB cycles
    own_log.delete();
    start_h(10, 16'h100, 16'hD000);
    start_a(2, 16'h200, 16'hE000);
    run_until_done(60, cyc);
    nh = 0;
    for (int i = 1; i < own_log.size() && own_log[i] == 1; i++) nh++;
    chk("t3_host_cycles", nh, 4);
    chk("t3_arr_after", own_log[5], 2);
    chk("t3_host_resume", own_log[7], 1);

    // host stalls mid-burst; counter must saturate
    start_h(3, 16'h300, 16'hF000);
    for (int i = 0; i < 10 && h_idx < 1; i++) run_cycle(1'b0);
    h_pause = 1;
    repeat (6) run_cycle(1'b0);
    chk("t4_gap_wen", bus.w_en, 0);
    chk("t4_gap_owner", bus.owner, OWN_HOST);
    start_a(1, 16'h380, 16'h1234);
    run_cycle(1'b0);
    chk("t4_sat_release", bus.owner, OWN_ARR);
    h_pause = 0;
    run_until_done(40, cyc);

    // reset mid array burst
    start_a(5, 16'h3C0, 16'h5500);
    for (int i = 0; i < 20 && a_idx < 2; i++) run_cycle(1'b0);
    #2 rst = 1'b1;
    #1;
    chk("t5_rst_wen", bus.w_en, 0);
    chk("t5_rst_owner", bus.owner, OWN_NONE);
    chk("t5_rst_aready", bus.a_ready, 0);
    drv_clear();
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    check_all();
    own_log.delete();
    start_h(1, 16'h0AA, 16'h0101);
    start_a(1, 16'h0BB, 16'h0202);
    run_until_done(20, cyc);
    chk("t5_tie_host", own_log[1], 1);

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      if (h_rem == 0 && $urandom_range(3) == 0)
        start_h($urandom_range(1, 8), $urandom_range(0, 1023),
                $urandom_range(0, 65535));
      if (a_rem == 0 && $urandom_range(3) == 0)
        start_a($urandom_range(1, 8), $urandom_range(0, 1023),
                $urandom_range(0, 65535));
      run_cycle(1'b1);
    end

`ifdef BUF_ARB_STATS_EN
    full_reset();
    start_h(70000, 0, 0);
    run_until_done(70100, cyc);
    chk("t6_h_sat", h_beats, 16'hFFFF);
    chk("t6_a_zero", a_beats, 0);
    start_a(3, 16'h010, 16'h7000);
    run_until_done(20, cyc);
    run_cycle(1'b0);
    chk("t6_a_count", a_beats, 3);
    chk("t6_h_still", h_beats, 16'hFFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
